pq_op_scheduler: RTL and testbench

Front-end stage that sits directly upstream of the register_array priority queue and drives its i_wrt/i_read/i_data pulse interface. Accepts pushes over a buffered valid/ready stream and pop requests over a valid/ready handshake, then issues at most one queue op per slot. A push and a pop that are both pending merge into a single replace op. Each queue op is followed by a configurable settle gap, and popped values are returned over a valid/ready result port.

---
 rtl/pq_pkg.sv | 19 +
 rtl/pq_op_scheduler_if.sv | 42 ++++
 rtl/sync_fifo.sv | 48 ++++
 rtl/pq_op_scheduler.sv | 122 ++++++++++++
 tb/tb_pq_op_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue op scheduler.
// Op encoding: bit0 drives the queue write pulse, bit1 the read pulse.
package pq_pkg;

  localparam int PQ_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REP  = 2'd3
  } op_e;

  typedef enum logic {
    IDLE,
    SETTLE
  } sched_state_e;

endpackage

// File: rtl/pq_op_scheduler_if.sv
// Stream, result and queue-side signals of the op scheduler.
// The slave modport is the scheduler's view.
interface pq_op_scheduler_if
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH = PQ_DATA_WIDTH
);

  logic                  i_push_valid;
  logic                  o_push_ready;
  logic [DATA_WIDTH-1:0] i_push_data;
  logic                  i_pop_req_valid;
  logic                  o_pop_req_ready;
  logic                  o_pop_valid;
  logic [DATA_WIDTH-1:0] o_pop_data;
  logic                  i_pop_ready;
  logic                  o_q_wrt;
  logic                  o_q_read;
  logic [DATA_WIDTH-1:0] o_q_data;
  logic                  i_q_full;
  logic                  i_q_empty;
  logic [DATA_WIDTH-1:0] i_q_data;

  modport slave (
    input  i_push_valid, i_push_data,
    input  i_pop_req_valid, i_pop_ready,
    input  i_q_full, i_q_empty, i_q_data,
    output o_push_ready, o_pop_req_ready,
    output o_pop_valid, o_pop_data,
    output o_q_wrt, o_q_read, o_q_data
  );

  modport master (
    output i_push_valid, i_push_data,
    output i_pop_req_valid, i_pop_ready,
    output i_q_full, i_q_empty, i_q_data,
    input  o_push_ready, o_pop_req_ready,
    input  o_pop_valid, o_pop_data,
    input  o_q_wrt, o_q_read, o_q_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output.
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           cnt;
  logic                  wr;
  logic                  rd;

  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

endmodule

// File: rtl/pq_op_scheduler.sv
// Issues enqueue/dequeue/replace pulses to the priority queue,
// one op per slot with a settle gap after each.
module pq_op_scheduler
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH = PQ_DATA_WIDTH,
  parameter int BUF_DEPTH  = 4,
  parameter int OP_GAP     = 5
) (
  input logic             CLK,
  input logic             RST,
  pq_op_scheduler_if.slave bus
);

  localparam int GW = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;

  sched_state_e          state;
  sched_state_e          state_n;
  op_e                   op;
  logic [GW-1:0]         gap_cnt;
  logic                  rdy_q;
  logic                  pop_pend;
  logic                  buf_full;
  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] buf_head;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  can_rep;
  logic                  can_deq;
  logic                  can_enq;
  logic                  q_wrt_r;
  logic                  q_read_r;
  logic [DATA_WIDTH-1:0] q_data_r;
  logic                  pop_valid_r;
  logic [DATA_WIDTH-1:0] pop_data_r;

  assign bus.o_push_ready    = rdy_q && !buf_full;
  assign bus.o_pop_req_ready = rdy_q && !pop_pend && !pop_valid_r;
  assign bus.o_pop_valid     = pop_valid_r;
  assign bus.o_pop_data      = pop_data_r;
  assign bus.o_q_wrt         = q_wrt_r;
  assign bus.o_q_read        = q_read_r;
  assign bus.o_q_data        = q_data_r;

  assign push_acc = bus.i_push_valid && bus.o_push_ready;
  assign pop_acc  = bus.i_pop_req_valid && bus.o_pop_req_ready;

  // Mutually exclusive forms of the priority order
  assign can_rep = pop_pend && !bus.i_q_empty && !buf_empty;
  assign can_deq = pop_pend && !bus.i_q_empty && buf_empty;
  assign can_enq = !buf_empty && !bus.i_q_full &&
                   !(pop_pend && !bus.i_q_empty);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_acc),
    .pop   (op[0]),
    .wdata (bus.i_push_data),
    .full  (buf_full),
    .empty (buf_empty),
    .head  (buf_head)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    op      = OP_NONE;
    state_n = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          can_rep: op = OP_REP;
          can_deq: op = OP_DEQ;
          can_enq: op = OP_ENQ;
          default: op = OP_NONE;
        endcase
        if (op != OP_NONE && OP_GAP > 0) state_n = SETTLE;
      end
      SETTLE: begin
        if (int'(gap_cnt) >= OP_GAP - 1) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdy_q       <= 1'b0;
      gap_cnt     <= '0;
      pop_pend    <= 1'b0;
      q_wrt_r     <= 1'b0;
      q_read_r    <= 1'b0;
      q_data_r    <= '0;
      pop_valid_r <= 1'b0;
      pop_data_r  <= '0;
    end else begin
      rdy_q    <= 1'b1;
      q_wrt_r  <= op[0];
      q_read_r <= op[1];
      if (op[0]) q_data_r <= buf_head;
      if (state == SETTLE && state_n == SETTLE)
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;
      if (pop_acc)    pop_pend <= 1'b1;
      else if (op[1]) pop_pend <= 1'b0;
      if (op[1]) begin
        pop_valid_r <= 1'b1;
        pop_data_r  <= bus.i_q_data;
      end else if (pop_valid_r && bus.i_pop_ready) begin
        pop_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pq_op_scheduler.sv
// Directed bench for pq_op_scheduler with op/result scoreboards.
module tb_pq_op_scheduler;

  localparam int DW     = 16;
  localparam int OP_GAP = 5;

  typedef struct packed {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
  } op_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  pq_op_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  pq_op_scheduler #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (4),
    .OP_GAP     (OP_GAP)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  op_t           exp_ops[$];
  logic [DW-1:0] exp_pop[$];
  int            pt[$];
  int            vectors = 0;
  int            errs = 0;
  int            cyc = 0;
  int            last_pulse = -1;
  logic          prev_v = 1'b0;
  logic          saw_wrt = 1'b0;
  logic [DW-1:0] last_qdata = '0;
  logic          acc;
  int            vals2[3] = '{100, 7, 900};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    op_t o;
    @(posedge CLK);
    #1;
    cyc++;
    if (!RST && (bus.o_q_wrt || bus.o_q_read)) begin
      o = {bus.o_q_wrt, bus.o_q_read, bus.o_q_data};
      if (bus.o_q_wrt) saw_wrt = 1'b1;
      pt.push_back(cyc);
      if (last_pulse >= 0)
        chk("gap", 32'(cyc - last_pulse >= OP_GAP + 1), 1);
      last_pulse = cyc;
      if (exp_ops.size() == 0) chk("op_unexpected", 32'(o), 0);
      else chk("op", 32'(o), 32'(exp_ops.pop_front()));
    end
    if (!RST && bus.o_pop_valid && !prev_v) begin
      if (exp_pop.size() == 0)
        chk("pop_unexpected", {15'b0, bus.o_pop_valid, bus.o_pop_data}, 0);
      else
        chk("pop_data", 32'(bus.o_pop_data), 32'(exp_pop.pop_front()));
    end
    prev_v = bus.o_pop_valid;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_ops.size() != 0 ||
         exp_pop.size() != 0); i++)
      tick();
    chk("drain_timeout", 32'(exp_ops.size() + exp_pop.size()), 0);
    repeat (8) tick();
  endtask

  initial begin
    bus.i_push_valid    = 1'b0;
    bus.i_push_data     = '0;
    bus.i_pop_req_valid = 1'b0;
    bus.i_pop_ready     = 1'b1;
    bus.i_q_full        = 1'b0;
    bus.i_q_empty       = 1'b1;
    bus.i_q_data        = '0;

    // 1: reset
    repeat (3) tick();
    chk("rst_push_ready", 32'(bus.o_push_ready), 0);
    chk("rst_pop_req_ready", 32'(bus.o_pop_req_ready), 0);
    chk("rst_pop_valid", 32'(bus.o_pop_valid), 0);
    chk("rst_pop_data", 32'(bus.o_pop_data), 0);
    chk("rst_q_wrt", 32'(bus.o_q_wrt), 0);
    chk("rst_q_read", 32'(bus.o_q_read), 0);
    chk("rst_q_data", 32'(bus.o_q_data), 0);
    RST = 1'b0;
    tick();
    chk("rel_push_ready", 32'(bus.o_push_ready), 1);
    chk("rel_pop_req_ready", 32'(bus.o_pop_req_ready), 1);
    chk("rel_pulses", {30'b0, bus.o_q_wrt, bus.o_q_read}, 0);

    // 2: three enqueues into an empty queue
    pt.delete();
    for (int i = 0; i < 3; i++) begin
      bus.i_push_valid = 1'b1;
      bus.i_push_data  = DW'(vals2[i]);
      exp_ops.push_back({1'b1, 1'b0, DW'(vals2[i])});
      last_qdata = DW'(vals2[i]);
      tick();
    end
    bus.i_push_valid = 1'b0;
    drain();
    chk("enq_count", 32'(pt.size()), 3);
    if (pt.size() == 3) begin
      chk("enq_space0", 32'(pt[1] - pt[0]), OP_GAP + 1);
      chk("enq_space1", 32'(pt[2] - pt[1]), OP_GAP + 1);
    end

    // 3: single dequeue
    bus.i_q_empty = 1'b0;
    bus.i_q_data  = 16'd900;
    chk("deq_req_ready", 32'(bus.o_pop_req_ready), 1);
    bus.i_pop_req_valid = 1'b1;
    exp_ops.push_back({1'b0, 1'b1, last_qdata});
    exp_pop.push_back(16'd900);
    tick();
    bus.i_pop_req_valid = 1'b0;
    tick();
    chk("deq_valid_lat", 32'(bus.o_pop_valid), 1);
    chk("deq_data_lat", 32'(bus.o_pop_data), 900);
    drain();

    // 4: push and pop together merge into replace
    bus.i_push_valid    = 1'b1;
    bus.i_push_data     = 16'd50;
    bus.i_pop_req_valid = 1'b1;
    exp_ops.push_back({1'b1, 1'b1, 16'd50});
    last_qdata = 16'd50;
    exp_pop.push_back(16'd900);
    tick();
    bus.i_push_valid    = 1'b0;
    bus.i_pop_req_valid = 1'b0;
    drain();

    // 5: queue full back-pressure, then release
    bus.i_q_full = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      bus.i_push_valid = 1'b1;
      bus.i_push_data  = DW'(v);
      tick();
    end
    chk("full_push_ready", 32'(bus.o_push_ready), 0);
    bus.i_push_data = 16'd5;
    repeat (6) tick();
    chk("full_hold_ready", 32'(bus.o_push_ready), 0);
    for (int v = 1; v <= 5; v++)
      exp_ops.push_back({1'b1, 1'b0, DW'(v)});
    last_qdata = 16'd5;
    bus.i_q_full = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = bus.o_push_ready;
      tick();
    end
    chk("push5_accepted", 32'(acc), 1);
    bus.i_push_valid = 1'b0;
    drain();

    // 6a: result held while consumer stalls
    bus.i_q_data        = 16'd321;
    bus.i_pop_ready     = 1'b0;
    bus.i_pop_req_valid = 1'b1;
    exp_ops.push_back({1'b0, 1'b1, last_qdata});
    exp_pop.push_back(16'd321);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", 32'(bus.o_pop_valid), 1);
      chk("hold_data", 32'(bus.o_pop_data), 321);
      chk("hold_req_ready", 32'(bus.o_pop_req_ready), 0);
      tick();
    end
    bus.i_pop_req_valid = 1'b0;
    bus.i_pop_ready     = 1'b1;
    tick();
    chk("hold_release", 32'(bus.o_pop_valid), 0);
    drain();

    // 6b: pop pending on empty queue waits for an enqueue
    bus.i_q_empty = 1'b1;
    chk("pend_req_ready", 32'(bus.o_pop_req_ready), 1);
    bus.i_pop_req_valid = 1'b1;
    tick();
    bus.i_pop_req_valid = 1'b0;
    repeat (10) tick();
    bus.i_push_valid = 1'b1;
    bus.i_push_data  = 16'd77;
    exp_ops.push_back({1'b1, 1'b0, 16'd77});
    last_qdata = 16'd77;
    tick();
    bus.i_push_valid = 1'b0;
    saw_wrt = 1'b0;
    for (int i = 0; i < 10 && !saw_wrt; i++) tick();
    chk("pend_enq_seen", 32'(saw_wrt), 1);
    bus.i_q_empty = 1'b0;
    bus.i_q_data  = 16'd77;
    exp_ops.push_back({1'b0, 1'b1, 16'd77});
    exp_pop.push_back(16'd77);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
